// File: rtl/pong_score_keeper.sv
// ============================================================================
// Module   : pong_score_keeper
// Function : Pong match sequencer and score keeper. Optional macro
//            SCORE_BLINK_EN blinks the scoring player's digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int POINT_FRAMES = 60
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       frame,
  input  logic       new_game,
  input  logic       exit_l,
  input  logic       exit_r,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       score_vis_l,
  output logic       score_vis_r,
  output logic       serve,
  output logic       serve_dir,
  output logic       playing,
  output logic       game_over,
  output logic       winner
);

  localparam logic [3:0] c_win_score = 4'(WIN_SCORE);
  localparam logic [7:0] c_last_frame = 8'(POINT_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PLAY = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t     r_state, w_state_n;
  logic [3:0] r_score_l, r_score_r, w_score_l_n, w_score_r_n;
  logic [7:0] r_cnt, w_cnt_n;
  logic       r_serve, w_serve_n;
  logic       r_serve_dir, w_serve_dir_n;
  logic       r_playing, r_game_over;
  logic       r_winner, w_winner_n;
  logic       r_vis_l, r_vis_r, w_vis_l_n, w_vis_r_n;

  always_comb begin
    w_state_n     = r_state;
    w_score_l_n   = r_score_l;
    w_score_r_n   = r_score_r;
    w_cnt_n       = r_cnt;
    w_serve_n     = 1'b0;
    w_serve_dir_n = r_serve_dir;
    w_winner_n    = r_winner;

    if (new_game) begin
      w_state_n   = S_WAIT;
      w_score_l_n = 4'd0;
      w_score_r_n = 4'd0;
      w_cnt_n     = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_WAIT: begin
          if (frame) begin
            if (r_cnt == c_last_frame) begin
              w_serve_n = 1'b1;
              w_state_n = S_PLAY;
              w_cnt_n   = 8'd0;
            end else begin
              w_cnt_n = r_cnt + 8'd1;
            end
          end
        end
        S_PLAY: begin
          // A double exit is a dead ball: replay without scoring.
          if (exit_l && exit_r) begin
            w_state_n = S_WAIT;
          end else if (exit_r) begin
            w_score_l_n   = r_score_l + 4'd1;
            w_serve_dir_n = 1'b1;
            w_cnt_n       = 8'd0;
            if (w_score_l_n == c_win_score) begin
              w_state_n  = S_OVER;
              w_winner_n = 1'b0;
            end else begin
              w_state_n = S_WAIT;
            end
          end else if (exit_l) begin
            w_score_r_n   = r_score_r + 4'd1;
            w_serve_dir_n = 1'b0;
            w_cnt_n       = 8'd0;
            if (w_score_r_n == c_win_score) begin
              w_state_n  = S_OVER;
              w_winner_n = 1'b1;
            end else begin
              w_state_n = S_WAIT;
            end
          end
        end
        S_OVER: begin
          if (frame) w_cnt_n = r_cnt + 8'd1;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

`ifdef SCORE_BLINK_EN
  logic r_blink_l, r_blink_r, w_blink_l_n, w_blink_r_n;

  // Blink owner is latched on the PLAY exit and dropped when WAIT ends.
  always_comb begin
    w_blink_l_n = r_blink_l;
    w_blink_r_n = r_blink_r;
    if (new_game || w_state_n == S_PLAY || w_state_n == S_IDLE) begin
      w_blink_l_n = 1'b0;
      w_blink_r_n = 1'b0;
    end else if (r_state == S_PLAY) begin
      w_blink_l_n = exit_r && !exit_l;
      w_blink_r_n = exit_l && !exit_r;
    end
    w_vis_l_n = !(w_blink_l_n && !w_cnt_n[3]);
    w_vis_r_n = !(w_blink_r_n && !w_cnt_n[3]);
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_blink_l <= 1'b0;
      r_blink_r <= 1'b0;
    end else begin
      r_blink_l <= w_blink_l_n;
      r_blink_r <= w_blink_r_n;
    end
  end
`else
  always_comb begin
    w_vis_l_n = 1'b1;
    w_vis_r_n = 1'b1;
  end
`endif

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_state     <= S_IDLE;
      r_score_l   <= 4'd0;
      r_score_r   <= 4'd0;
      r_cnt       <= 8'd0;
      r_serve     <= 1'b0;
      r_serve_dir <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_vis_l     <= 1'b1;
      r_vis_r     <= 1'b1;
    end else begin
      r_state     <= w_state_n;
      r_score_l   <= w_score_l_n;
      r_score_r   <= w_score_r_n;
      r_cnt       <= w_cnt_n;
      r_serve     <= w_serve_n;
      r_serve_dir <= w_serve_dir_n;
      r_playing   <= (w_state_n == S_PLAY);
      r_game_over <= (w_state_n == S_OVER);
      r_winner    <= w_winner_n;
      r_vis_l     <= w_vis_l_n;
      r_vis_r     <= w_vis_r_n;
    end
  end

  assign score_l     = r_score_l;
  assign score_r     = r_score_r;
  assign score_vis_l = r_vis_l;
  assign score_vis_r = r_vis_r;
  assign serve       = r_serve;
  assign serve_dir   = r_serve_dir;
  assign playing     = r_playing;
  assign game_over   = r_game_over;
  assign winner      = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_pong_score_keeper.sv
// ============================================================================
// Module   : tb_pong_score_keeper
// Function : Scoreboard bench for pong_score_keeper against a rule-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pong_score_keeper;

  localparam int WIN = 9;
  localparam int PF  = 60;
  localparam int P_IDLE = 0, P_WAIT = 1, P_PLAY = 2, P_OVER = 3;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  logic frame = 1'b0, new_game = 1'b0, exit_l = 1'b0, exit_r = 1'b0;
  logic [3:0] score_l, score_r;
  logic score_vis_l, score_vis_r, serve, serve_dir, playing, game_over, winner;

  pong_score_keeper #(.WIN_SCORE(WIN), .POINT_FRAMES(PF)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame), .new_game(new_game),
    .exit_l(exit_l), .exit_r(exit_r), .score_l(score_l), .score_r(score_r),
    .score_vis_l(score_vis_l), .score_vis_r(score_vis_r), .serve(serve),
    .serve_dir(serve_dir), .playing(playing), .game_over(game_over), .winner(winner)
  );

  always #5 clk_pix = ~clk_pix;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  logic [14:0] exp_q[$];

  // Rule-level game model: phase, scores, frames seen in the current pause.
  int m_phase, m_sl, m_sr, m_dir, m_win, m_serve, m_wait_frames, m_over_frames, m_blink;

  function automatic void model_reset();
    m_phase = P_IDLE; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0; m_serve = 0;
    m_wait_frames = 0; m_over_frames = 0; m_blink = -1;
  endfunction

  function automatic void model_step(input logic f, input logic ng, input logic el, input logic er);
    m_serve = 0;
    if (ng) begin
      m_phase = P_WAIT; m_sl = 0; m_sr = 0; m_wait_frames = 0; m_blink = -1;
    end else if (m_phase == P_WAIT) begin
      if (f) begin
        m_wait_frames++;
        if (m_wait_frames == PF) begin
          m_serve = 1; m_phase = P_PLAY; m_wait_frames = 0; m_blink = -1;
        end
      end
    end else if (m_phase == P_PLAY) begin
      if (el && er) begin
        m_phase = P_WAIT; m_blink = -1;
      end else if (er || el) begin
        if (er) begin m_sl++; m_dir = 1; m_blink = 0; end
        else    begin m_sr++; m_dir = 0; m_blink = 1; end
        if (m_sl == WIN || m_sr == WIN) begin
          m_phase = P_OVER; m_win = er ? 0 : 1; m_over_frames = 0;
        end else begin
          m_phase = P_WAIT;
        end
      end
    end else if (m_phase == P_OVER) begin
      if (f) m_over_frames++;
    end
  endfunction

  function automatic logic [14:0] model_vec();
    logic vl, vr;
    int n;
    vl = 1'b1; vr = 1'b1;
`ifdef SCORE_BLINK_EN
    n = (m_phase == P_OVER) ? m_over_frames : m_wait_frames;
    if ((m_phase == P_WAIT || m_phase == P_OVER) && ((n / 8) % 2 == 0)) begin
      if (m_blink == 0) vl = 1'b0;
      if (m_blink == 1) vr = 1'b0;
    end
`else
    n = 0;
`endif
    return {4'(m_sl), 4'(m_sr), vl, vr, 1'(m_serve), 1'(m_dir),
            1'(m_phase == P_PLAY), 1'(m_phase == P_OVER), 1'(m_win)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {score_l, score_r, score_vis_l, score_vis_r, serve, serve_dir,
            playing, game_over, winner};
  endfunction

  function automatic string fmt(input logic [14:0] v);
    return $sformatf("sl=%0d sr=%0d vis=%b%b serve=%b dir=%b play=%b over=%b win=%b",
                     v[14:11], v[10:7], v[6], v[5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got [%s] expected [%s]", name, $time, fmt(got), fmt(exp));
    end
  endtask

  task automatic drive(input logic f, input logic ng, input logic el, input logic er);
    @(negedge clk_pix);
    frame = f; new_game = ng; exit_l = el; exit_r = er;
    model_step(f, ng, el, er);
    exp_q.push_back(model_vec());
  endtask

  task automatic wait_serve();
    int k;
    k = 0;
    while (m_phase == P_WAIT && k < 400) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      k++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk_pix) begin
    #1;
    if (mon_en && !rst_pix && exp_q.size() != 0) begin
      logic [14:0] e;
      e = exp_q.pop_front();
      check("scoreboard", dut_vec(), e);
    end
  end

  localparam logic [14:0] RESET_VEC = {4'd0, 4'd0, 1'b1, 1'b1, 5'b00000};

  initial begin
    model_reset();
    #12;
    check("reset_state", dut_vec(), RESET_VEC);
    @(negedge clk_pix);
    rst_pix = 1'b0;
    mon_en = 1'b1;

    // First match: serve, then build a 3/5 score.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    wait_serve();
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 1'b0, 1'b1); wait_serve(); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if (i < 4) wait_serve();
    end
    for (int i = 0; i < 20; i++) drive(1'(i % 2), 1'b0, 1'(i % 3 == 0), 1'(i % 5 == 0));

    // Reset asserted between clock edges while in WAIT at 3/5.
    @(posedge clk_pix);
    #3;
    rst_pix = 1'b1;
    #1;
    check("async_reset", dut_vec(), RESET_VEC);
    model_reset();
    repeat (2) @(negedge clk_pix);
    rst_pix = 1'b0;

    // Right player runs out the match, then exits and new_game in OVER.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    wait_serve();
    for (int i = 0; i < WIN; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if (m_phase != P_OVER) wait_serve();
    end
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 1'(i % 2), 1'(i % 3 == 0));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    wait_serve();

    // Dead ball, then exits during WAIT, then a held new_game.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'(i % 2), 1'(i % 2 == 0));
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    wait_serve();

    // Randomized play.
    for (int i = 0; i < 25000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3999) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
    end

    repeat (3) @(negedge clk_pix);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
